// File: rtl/usb_rx_pkt_ctrl_pkg.sv
// Shared types, constants and the token CRC5 helper for the USB full-speed
// receive packet controller.
package usb_rx_pkg;

  typedef enum logic [3:0] {
    PID_OUT   = 4'b0001,
    PID_IN    = 4'b1001,
    PID_SETUP = 4'b1101,
    PID_DATA0 = 4'b0011,
    PID_DATA1 = 4'b1011,
    PID_ACK   = 4'b0010,
    PID_NAK   = 4'b1010,
    PID_STALL = 4'b1110
  } pid_t;

  typedef enum logic [2:0] {
    ERR_NONE      = 3'd0,
    ERR_SYNC      = 3'd1,
    ERR_PID       = 3'd2,
    ERR_CRC       = 3'd3,
    ERR_LEN       = 3'd4,
    ERR_OVF       = 3'd5,
    ERR_ADDR      = 3'd6,
    ERR_EOP_EARLY = 3'd7
  } rx_err_t;

  typedef enum logic [3:0] {
    ST_IDLE, ST_SYNC, ST_PID, ST_TOKEN, ST_HSHAKE,
    ST_DATA, ST_CHECK, ST_ERROR, ST_EOP_LOW
  } rx_state_t;

  typedef enum logic [1:0] {
    KIND_NONE, KIND_TOKEN, KIND_DATA, KIND_HSHAKE
  } pkt_kind_t;

  localparam logic [7:0]  SYNC_BYTE     = 8'h80;
  localparam logic [4:0]  CRC5_POLY     = 5'h05;
  localparam logic [4:0]  CRC5_RESIDUE  = 5'h0C;
  localparam logic [15:0] CRC16_POLY    = 16'h8005;
  localparam logic [15:0] CRC16_RESIDUE = 16'h800D;

  function automatic pkt_kind_t pid_kind(input logic [3:0] code);
    case (code)
      PID_OUT, PID_IN, PID_SETUP:  return KIND_TOKEN;
      PID_DATA0, PID_DATA1:        return KIND_DATA;
      PID_ACK, PID_NAK, PID_STALL: return KIND_HSHAKE;
      default:                     return KIND_NONE;
    endcase
  endfunction

  // Runs the whole token body, CRC field included; a clean token leaves CRC5_RESIDUE.
  function automatic logic [4:0] crc5_16b(input logic [15:0] bits);
    logic [4:0] crc;
    crc = 5'h1F;
    for (int i = 0; i < 16; i++) begin
      if (crc[4] ^ bits[i]) crc = {crc[3:0], 1'b0} ^ CRC5_POLY;
      else                  crc = {crc[3:0], 1'b0};
    end
    return crc;
  endfunction

endpackage

// File: rtl/usb_rx_pkt_ctrl_if.sv
// Byte-stream and RX FIFO signals of the receive packet controller.
// master = controller side, slave = receiver/FIFO side.
interface usb_rx_pkt_ctrl_if #(
  parameter int OCC_W = 7
);
  logic             d_edge;
  logic             eop;
  logic             byte_received;
  logic [7:0]       rcv_data;
  logic [OCC_W-1:0] buffer_occupancy;
  logic [7:0]       rx_packet_data;
  logic             store_rx_packet_data;
  logic             flush;

  modport master (
    input  d_edge, eop, byte_received, rcv_data, buffer_occupancy,
    output rx_packet_data, store_rx_packet_data, flush
  );

  modport slave (
    output d_edge, eop, byte_received, rcv_data, buffer_occupancy,
    input  rx_packet_data, store_rx_packet_data, flush
  );
endinterface

// File: rtl/usb_rx_pkt_ctrl_crc16.sv
// Combinational CRC16 step over one received byte, bit 0 first.
module usb_crc16_byte
  import usb_rx_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data_in,
  output logic [15:0] crc_out
);

  logic [15:0] crc;

  always_comb begin
    crc = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (crc[15] ^ data_in[i]) crc = {crc[14:0], 1'b0} ^ CRC16_POLY;
      else                      crc = {crc[14:0], 1'b0};
    end
    crc_out = crc;
  end

endmodule

// File: rtl/usb_rx_pkt_ctrl.sv
// USB full-speed RX packet controller: sync/PID/payload sequencing, CRC5/CRC16
// checks, token decode with address filter, payload hold-back and error typing.
module usb_rx_pkt_ctrl
  import usb_rx_pkg::*;
#(
  parameter int BUF_DEPTH = 64,
  parameter int OCC_W     = $clog2(BUF_DEPTH) + 1,
  parameter int MAX_DATA  = 64,
  parameter int CNT_W     = $clog2(MAX_DATA + 1),
  parameter bit CHECK_CRC = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  usb_rx_pkt_ctrl_if.master   bus,
  input  logic [6:0]          dev_addr,
  input  logic                addr_check_en,
  output logic                rx_transfer_active,
  output logic [3:0]          rx_packet,
  output logic [6:0]          rx_token_addr,
  output logic [3:0]          rx_token_endp,
  output logic [CNT_W-1:0]    rx_byte_count,
  output logic                rx_data_ready,
  output logic                rx_error,
  output logic [2:0]          rx_error_code
);

  rx_state_t   state;
  pkt_kind_t   kind;
  pkt_kind_t   pid_kind_w;
  rx_err_t     err_code;
  logic        err_hit;
  logic        pid_ok;
  logic        push_due;
  logic [1:0]  rx_cnt;
  logic [7:0]  tok0, tok1;
  logic [7:0]  hold0, hold1;
  logic [15:0] crc16_q, crc16_nxt;

  usb_crc16_byte u_crc16 (
    .crc_in  (crc16_q),
    .data_in (bus.rcv_data),
    .crc_out (crc16_nxt)
  );

  assign rx_transfer_active = (state != ST_IDLE);
  assign err_hit            = (err_code != ERR_NONE);

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    err_code   = ERR_NONE;
    pid_kind_w = pid_kind(bus.rcv_data[3:0]);
    pid_ok     = (bus.rcv_data[7:4] == ~bus.rcv_data[3:0]) && (pid_kind_w != KIND_NONE);
    push_due   = (state == ST_DATA) && bus.byte_received && (rx_cnt == 2'd2);
    case (state)
      ST_SYNC: begin
        if (bus.byte_received && bus.rcv_data != SYNC_BYTE) err_code = ERR_SYNC;
        else if (bus.eop)                                    err_code = ERR_EOP_EARLY;
      end
      ST_PID: begin
        if (bus.byte_received && !pid_ok)         err_code = ERR_PID;
        else if (bus.eop && !bus.byte_received)   err_code = ERR_EOP_EARLY;
      end
      ST_TOKEN: begin
        // eop is judged against the count including a byte arriving this cycle
        if (bus.byte_received && rx_cnt == 2'd2) err_code = ERR_LEN;
        else if (bus.eop && (rx_cnt == 2'd0 || (rx_cnt == 2'd1 && !bus.byte_received)))
          err_code = ERR_LEN;
      end
      ST_HSHAKE: begin
        if (bus.byte_received) err_code = ERR_LEN;
      end
      ST_DATA: begin
        if (push_due && (rx_byte_count == CNT_W'(MAX_DATA) ||
                         bus.buffer_occupancy >= OCC_W'(BUF_DEPTH)))
          err_code = ERR_OVF;
      end
      ST_CHECK: begin
        if (kind != KIND_HSHAKE && rx_cnt != 2'd2)
          err_code = ERR_LEN;
        else if (CHECK_CRC && kind == KIND_DATA && crc16_q != CRC16_RESIDUE)
          err_code = ERR_CRC;
        else if (CHECK_CRC && kind == KIND_TOKEN && crc5_16b({tok1, tok0}) != CRC5_RESIDUE)
          err_code = ERR_CRC;
        else if (kind == KIND_TOKEN && addr_check_en && tok0[6:0] != dev_addr)
          err_code = ERR_ADDR;
      end
      default: ;
    endcase
  end

  // NOTE: non-blocking assignments only; every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                    <= ST_IDLE;
      kind                     <= KIND_NONE;
      rx_cnt                   <= '0;
      tok0                     <= '0;
      tok1                     <= '0;
      hold0                    <= '0;
      hold1                    <= '0;
      crc16_q                  <= '0;
      rx_packet                <= '0;
      rx_token_addr            <= '0;
      rx_token_endp            <= '0;
      rx_byte_count            <= '0;
      rx_data_ready            <= 1'b0;
      rx_error                 <= 1'b0;
      rx_error_code            <= ERR_NONE;
      bus.rx_packet_data       <= '0;
      bus.store_rx_packet_data <= 1'b0;
      bus.flush                <= 1'b0;
    end else begin
      bus.store_rx_packet_data <= 1'b0;
      bus.flush                <= 1'b0;
      rx_data_ready            <= 1'b0;
      if (err_hit) begin
        bus.flush     <= 1'b1;
        rx_error      <= 1'b1;
        rx_error_code <= err_code;
        state         <= bus.eop ? ST_EOP_LOW : ST_ERROR;
      end else begin
        case (state)
          ST_IDLE: if (bus.d_edge) state <= ST_SYNC;
          ST_SYNC: begin
            if (bus.byte_received) begin
              state         <= ST_PID;
              rx_error      <= 1'b0;
              rx_error_code <= ERR_NONE;
            end
          end
          ST_PID: begin
            if (bus.byte_received) begin
              rx_packet <= bus.rcv_data[3:0];
              kind      <= pid_kind_w;
              rx_cnt    <= '0;
              if (pid_kind_w == KIND_DATA) begin
                bus.flush     <= 1'b1;
                rx_byte_count <= '0;
                crc16_q       <= 16'hFFFF;
              end
              if (bus.eop)                       state <= ST_CHECK;
              else if (pid_kind_w == KIND_TOKEN) state <= ST_TOKEN;
              else if (pid_kind_w == KIND_DATA)  state <= ST_DATA;
              else                               state <= ST_HSHAKE;
            end
          end
          ST_TOKEN: begin
            if (bus.byte_received) begin
              if (rx_cnt == 2'd0) tok0 <= bus.rcv_data;
              else                tok1 <= bus.rcv_data;
              rx_cnt <= rx_cnt + 2'd1;
            end
            if (bus.eop) state <= ST_CHECK;
          end
          ST_HSHAKE: if (bus.eop) state <= ST_CHECK;
          ST_DATA: begin
            // The newest two bytes are held back; at eop they are the CRC16.
            if (bus.byte_received) begin
              crc16_q <= crc16_nxt;
              hold0   <= hold1;
              hold1   <= bus.rcv_data;
              if (rx_cnt == 2'd2) begin
                bus.store_rx_packet_data <= 1'b1;
                bus.rx_packet_data       <= hold0;
                rx_byte_count            <= rx_byte_count + CNT_W'(1);
              end else begin
                rx_cnt <= rx_cnt + 2'd1;
              end
            end
            if (bus.eop) state <= ST_CHECK;
          end
          ST_CHECK: begin
            rx_data_ready <= 1'b1;
            if (kind == KIND_TOKEN) begin
              rx_token_addr <= tok0[6:0];
              rx_token_endp <= {tok1[2:0], tok0[7]};
            end
            state <= ST_EOP_LOW;
          end
          ST_ERROR:   if (bus.eop)  state <= ST_EOP_LOW;
          ST_EOP_LOW: if (!bus.eop) state <= ST_IDLE;
          default:    state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usb_rx_pkt_ctrl.sv
// Directed bench for usb_rx_pkt_ctrl: three instances (default, CRC ignored,
// MAX_DATA=8) share one stimulus; pushed bytes are scoreboarded per instance.
module tb_usb_rx_pkt_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, d_edge, eop, byte_received, addr_check_en;
  logic [7:0] rcv_data;
  logic [6:0] occ, dev_addr;

  usb_rx_pkt_ctrl_if #(.OCC_W(7)) if_a ();
  usb_rx_pkt_ctrl_if #(.OCC_W(7)) if_b ();
  usb_rx_pkt_ctrl_if #(.OCC_W(7)) if_c ();

  assign if_a.d_edge = d_edge;  assign if_b.d_edge = d_edge;  assign if_c.d_edge = d_edge;
  assign if_a.eop = eop;        assign if_b.eop = eop;        assign if_c.eop = eop;
  assign if_a.byte_received = byte_received;
  assign if_b.byte_received = byte_received;
  assign if_c.byte_received = byte_received;
  assign if_a.rcv_data = rcv_data; assign if_b.rcv_data = rcv_data; assign if_c.rcv_data = rcv_data;
  assign if_a.buffer_occupancy = occ;
  assign if_b.buffer_occupancy = occ;
  assign if_c.buffer_occupancy = occ;

  logic       act_a, act_b, act_c, rdy_a, rdy_b, rdy_c, err_a, err_b, err_c;
  logic [3:0] pkt_a, pkt_b, pkt_c, tendp_a, tendp_b, tendp_c;
  logic [6:0] taddr_a, taddr_b, taddr_c, cnt_a, cnt_b;
  logic [3:0] cnt_c;
  logic [2:0] code_a, code_b, code_c;

  usb_rx_pkt_ctrl #(.BUF_DEPTH(64), .MAX_DATA(64), .CHECK_CRC(1'b1)) dut_a (
    .clk(clk), .rst(rst), .bus(if_a), .dev_addr(dev_addr), .addr_check_en(addr_check_en),
    .rx_transfer_active(act_a), .rx_packet(pkt_a), .rx_token_addr(taddr_a),
    .rx_token_endp(tendp_a), .rx_byte_count(cnt_a), .rx_data_ready(rdy_a),
    .rx_error(err_a), .rx_error_code(code_a));

  usb_rx_pkt_ctrl #(.BUF_DEPTH(64), .MAX_DATA(64), .CHECK_CRC(1'b0)) dut_b (
    .clk(clk), .rst(rst), .bus(if_b), .dev_addr(dev_addr), .addr_check_en(addr_check_en),
    .rx_transfer_active(act_b), .rx_packet(pkt_b), .rx_token_addr(taddr_b),
    .rx_token_endp(tendp_b), .rx_byte_count(cnt_b), .rx_data_ready(rdy_b),
    .rx_error(err_b), .rx_error_code(code_b));

  usb_rx_pkt_ctrl #(.BUF_DEPTH(64), .MAX_DATA(8), .CHECK_CRC(1'b1)) dut_c (
    .clk(clk), .rst(rst), .bus(if_c), .dev_addr(dev_addr), .addr_check_en(addr_check_en),
    .rx_transfer_active(act_c), .rx_packet(pkt_c), .rx_token_addr(taddr_c),
    .rx_token_endp(tendp_c), .rx_byte_count(cnt_c), .rx_data_ready(rdy_c),
    .rx_error(err_c), .rx_error_code(code_c));

  int checks = 0;
  int passed = 0;
  int n_flush [3] = '{0, 0, 0};
  int n_rdy   [3] = '{0, 0, 0};
  int f0 [3];
  int r0 [3];
  logic [7:0] exp_a [$];
  logic [7:0] exp_b [$];
  logic [7:0] exp_c [$];
  logic [7:0] pay_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (if_a.flush === 1'b1) n_flush[0]++;
    if (if_b.flush === 1'b1) n_flush[1]++;
    if (if_c.flush === 1'b1) n_flush[2]++;
    if (rdy_a === 1'b1) n_rdy[0]++;
    if (rdy_b === 1'b1) n_rdy[1]++;
    if (rdy_c === 1'b1) n_rdy[2]++;
    if (if_a.store_rx_packet_data === 1'b1) begin
      check("a_store_expected", 32'(exp_a.size() != 0), 1);
      if (exp_a.size() != 0) check("a_store_data", if_a.rx_packet_data, exp_a.pop_front());
    end
    if (if_b.store_rx_packet_data === 1'b1) begin
      check("b_store_expected", 32'(exp_b.size() != 0), 1);
      if (exp_b.size() != 0) check("b_store_data", if_b.rx_packet_data, exp_b.pop_front());
    end
    if (if_c.store_rx_packet_data === 1'b1) begin
      check("c_store_expected", 32'(exp_c.size() != 0), 1);
      if (exp_c.size() != 0) check("c_store_data", if_c.rx_packet_data, exp_c.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] bitrev(input logic [7:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = x[7-i];
    return r;
  endfunction

  function automatic logic [15:0] token_bytes(input logic [6:0] addr, input logic [3:0] endp);
    logic [10:0] f;
    logic [4:0]  c;
    f = {endp, addr};
    c = 5'h1F;
    for (int i = 0; i < 11; i++) begin
      if (c[4] ^ f[i]) c = {c[3:0], 1'b0} ^ 5'h05;
      else             c = {c[3:0], 1'b0};
    end
    // {byte1, byte0}; inverted CRC goes out x^4 first
    return {~c[0], ~c[1], ~c[2], ~c[3], ~c[4], f[10:8], f[7:0]};
  endfunction

  function automatic logic [15:0] payload_crc16();
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (pay_q[k])
      for (int i = 0; i < 8; i++) begin
        if (c[15] ^ pay_q[k][i]) c = {c[14:0], 1'b0} ^ 16'h8005;
        else                     c = {c[14:0], 1'b0};
      end
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rcv_data = b;
    byte_received = 1'b1;
    tick();
    byte_received = 1'b0;
    tick();
  endtask

  task automatic start_pkt(input logic [7:0] pid);
    d_edge = 1'b1;
    tick();
    d_edge = 1'b0;
    send_byte(8'h80);
    send_byte(pid);
  endtask

  task automatic end_pkt();
    eop = 1'b1;
    repeat (3) tick();
    eop = 1'b0;
    repeat (2) tick();
  endtask

  task automatic snap();
    for (int i = 0; i < 3; i++) begin
      f0[i] = n_flush[i];
      r0[i] = n_rdy[i];
    end
  endtask

  task automatic send_token(input logic [7:0] pid, input logic [6:0] addr, input logic [3:0] endp);
    logic [15:0] tb;
    tb = token_bytes(addr, endp);
    start_pkt(pid);
    send_byte(tb[7:0]);
    send_byte(tb[15:8]);
    end_pkt();
  endtask

  // Payload from pay_q; flip_idx corrupts one bit after the CRC is computed.
  task automatic send_data(input logic [7:0] pid, input int flip_idx,
                           input int n_a, input int n_b, input int n_c);
    logic [15:0] crc;
    logic [7:0]  b;
    crc = payload_crc16();
    start_pkt(pid);
    for (int i = 0; i < pay_q.size(); i++) begin
      b = pay_q[i];
      if (i == flip_idx) b = b ^ 8'h04;
      if (i < n_a) exp_a.push_back(b);
      if (i < n_b) exp_b.push_back(b);
      if (i < n_c) exp_c.push_back(b);
      send_byte(b);
    end
    send_byte(bitrev(~crc[15:8]));
    send_byte(bitrev(~crc[7:0]));
    end_pkt();
  endtask

  initial begin
    rst = 1'b1; d_edge = 1'b0; eop = 1'b0; byte_received = 1'b0; rcv_data = 8'h00;
    occ = 7'd0; dev_addr = 7'h15; addr_check_en = 1'b1;
    repeat (3) tick();
    check("rst_active", act_a, 0);
    check("rst_packet", pkt_a, 0);
    check("rst_taddr", taddr_a, 0);
    check("rst_tendp", tendp_a, 0);
    check("rst_count", cnt_a, 0);
    check("rst_pdata", if_a.rx_packet_data, 0);
    check("rst_store", if_a.store_rx_packet_data, 0);
    check("rst_flush", if_a.flush, 0);
    check("rst_ready", rdy_a, 0);
    check("rst_error", err_a, 0);
    check("rst_code", code_a, 0);
    rst = 1'b0;
    tick();

    // Good OUT token to our own address
    snap();
    d_edge = 1'b1; tick(); d_edge = 1'b0;
    check("active_in_pkt", act_a, 1);
    send_byte(8'h80);
    send_byte(8'hE1);
    begin
      logic [15:0] tb;
      tb = token_bytes(7'h15, 4'hE);
      send_byte(tb[7:0]);
      send_byte(tb[15:8]);
    end
    end_pkt();
    check("tok_ready", n_rdy[0] - r0[0], 1);
    check("tok_flush", n_flush[0] - f0[0], 0);
    check("tok_packet", pkt_a, 4'b0001);
    check("tok_addr", taddr_a, 7'h15);
    check("tok_endp", tendp_a, 4'hE);
    check("tok_error", err_a, 0);
    check("tok_idle", act_a, 0);

    // Same token, different device address
    snap();
    dev_addr = 7'h16;
    send_token(8'hE1, 7'h15, 4'hE);
    check("addr_error", err_a, 1);
    check("addr_code", code_a, 6);
    check("addr_flush", n_flush[0] - f0[0], 1);
    check("addr_ready", n_rdy[0] - r0[0], 0);
    check("addr_keep_taddr", taddr_a, 7'h15);
    dev_addr = 7'h15;

    // DATA0 with four payload bytes
    snap();
    pay_q = '{8'h00, 8'h01, 8'h02, 8'h03};
    send_data(8'hC3, -1, 4, 4, 4);
    check("data_flush", n_flush[0] - f0[0], 1);
    check("data_count", cnt_a, 4);
    check("data_ready", n_rdy[0] - r0[0], 1);
    check("data_error", err_a, 0);
    check("data_code", code_a, 0);
    check("data_packet", pkt_a, 4'b0011);

    // One payload bit flipped: CRC error unless CRC checking is off
    snap();
    send_data(8'hC3, 2, 4, 4, 4);
    check("crc_code_a", code_a, 3);
    check("crc_ready_a", n_rdy[0] - r0[0], 0);
    check("crc_flush_a", n_flush[0] - f0[0], 2);
    check("crc_error_b", err_b, 0);
    check("crc_ready_b", n_rdy[1] - r0[1], 1);
    check("crc_count_b", cnt_b, 4);
    check("crc_code_c", code_c, 3);

    // Bad PID complement, then a good ACK clears the error
    snap();
    start_pkt(8'hE2);
    end_pkt();
    check("pid_code", code_a, 2);
    check("pid_flush", n_flush[0] - f0[0], 1);
    snap();
    start_pkt(8'hD2);
    end_pkt();
    check("ack_error", err_a, 0);
    check("ack_code", code_a, 0);
    check("ack_packet", pkt_a, 4'b0010);
    check("ack_ready", n_rdy[0] - r0[0], 1);

    // Ten payload bytes: overflows only the MAX_DATA=8 instance
    snap();
    pay_q.delete();
    for (int i = 0; i < 10; i++) pay_q.push_back(8'hA0 + 8'(i));
    send_data(8'h4B, -1, 10, 10, 8);
    check("long_count_a", cnt_a, 10);
    check("long_ready_a", n_rdy[0] - r0[0], 1);
    check("long_packet_a", pkt_a, 4'b1011);
    check("ovf_code_c", code_c, 5);
    check("ovf_count_c", cnt_c, 8);
    check("ovf_flush_c", n_flush[2] - f0[2], 2);
    check("ovf_ready_c", n_rdy[2] - r0[2], 0);

    // Full RX FIFO at the first push
    snap();
    occ = 7'd64;
    pay_q = '{8'h10, 8'h20, 8'h30, 8'h40};
    send_data(8'hC3, -1, 0, 0, 0);
    occ = 7'd0;
    check("full_code_a", code_a, 5);
    check("full_count_a", cnt_a, 0);
    check("full_flush_a", n_flush[0] - f0[0], 2);
    check("full_code_b", code_b, 5);

    // Reset in the middle of a payload
    start_pkt(8'hC3);
    exp_a.push_back(8'h11); exp_b.push_back(8'h11); exp_c.push_back(8'h11);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    check("mid_count", cnt_a, 1);
    snap();
    rst = 1'b1;
    tick();
    check("mrst_active", act_a, 0);
    check("mrst_packet", pkt_a, 0);
    check("mrst_count", cnt_a, 0);
    check("mrst_pdata", if_a.rx_packet_data, 0);
    check("mrst_taddr", taddr_a, 0);
    check("mrst_code", code_a, 0);
    tick();
    check("mrst_no_flush", n_flush[0] - f0[0], 0);
    check("mrst_no_ready", n_rdy[0] - r0[0], 0);
    rst = 1'b0;
    repeat (2) tick();

    check("queue_a_empty", exp_a.size(), 0);
    check("queue_b_empty", exp_b.size(), 0);
    check("queue_c_empty", exp_c.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/usb_rx_pkt_ctrl.md
Name: usb_rx_pkt_ctrl

Overview:
Parametrised USB full-speed receive packet controller. It is the next-generation RX control unit and sits between the bit-level receiver and the RX data FIFO. On top of sync/PID/payload sequencing it adds PID complement checking, CRC5/CRC16 verification, token address/endpoint extraction with address filtering, STALL acceptance, a configurable payload limit and typed error reporting.

Parameters:
BUF_DEPTH, 64, RX FIFO depth in bytes; the overflow threshold.
OCC_W, $clog2(BUF_DEPTH)+1, width of buffer_occupancy.
MAX_DATA, 64, maximum payload bytes per data packet, CRC excluded.
CNT_W, $clog2(MAX_DATA+1), width of rx_byte_count.
CHECK_CRC, 1, 1 = CRC failures raise an error; 0 = CRC is computed but ignored.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
d_edge  in  1  line edge detected (start of packet)
eop  in  1  end-of-packet level from receiver
byte_received  in  1  1-cycle pulse: rcv_data holds a new byte (bit 0 first on wire)
rcv_data  in  8  received byte
buffer_occupancy  in  OCC_W  RX FIFO fill level
dev_addr  in  7  own device address
addr_check_en  in  1  1 = reject tokens whose address is not dev_addr
rx_transfer_active  out  1  packet reception in progress
rx_packet  out  4  last valid PID code
rx_token_addr  out  7  address field of last good token
rx_token_endp  out  4  endpoint field of last good token
rx_byte_count  out  CNT_W  payload bytes stored for current/last data packet
rx_packet_data  out  8  byte to FIFO, valid with store_rx_packet_data
store_rx_packet_data  out  1  FIFO push strobe
flush  out  1  1-cycle FIFO clear strobe
rx_data_ready  out  1  1-cycle "packet accepted" strobe
rx_error  out  1  error flag
rx_error_code  out  3  error cause

Behaviour:
- Reset: state IDLE. All outputs 0; rx_error_code = NONE. Reset mid-packet aborts silently: no flush and no strobes.
- States: IDLE, SYNC, PID, TOKEN, HSHAKE, DATA, CHECK, ERROR, EOP_LOW.
- IDLE: d_edge -> SYNC. rx_transfer_active is 1 in every state except IDLE.
- SYNC: on the first byte, 8'h80 -> PID; otherwise -> ERROR(SYNC). eop -> ERROR(EOP_EARLY). Entering PID clears rx_error and rx_error_code.
- PID: on the byte, rcv_data[7:4] must equal ~rcv_data[3:0], else ERROR(PID).
  - Unknown code -> ERROR(PID).
  - Otherwise rx_packet <= rcv_data[3:0] at that edge.
  - OUT/IN/SETUP(1101) -> TOKEN; DATA0/DATA1 -> DATA with 1-cycle flush and rx_byte_count <= 0; ACK/NAK/STALL -> HSHAKE.
  - eop before the byte -> ERROR(EOP_EARLY).
- TOKEN: collect exactly 2 bytes. A third byte -> ERROR(LEN). eop with fewer than 2 bytes -> ERROR(LEN). eop with 2 bytes -> CHECK.
  - CRC5 check over the 16 bits: poly 5'h05, init 5'h1F, LSB-first, residue 5'h0C.
  - addr = byte0[6:0]; endp = {byte1[2:0], byte0[7]}.
- HSHAKE: eop -> CHECK (always good). Any byte -> ERROR(LEN).
- DATA: 2-byte hold-back pipeline. When byte n arrives with n ≥ 2, byte n-2 is pushed: store_rx_packet_data = 1 for 1 cycle, rx_packet_data = that byte, rx_byte_count++.
  - If the push would make the count exceed MAX_DATA, or buffer_occupancy ≥ BUF_DEPTH at the push -> ERROR(OVF) and no push.
  - eop -> CHECK. The held bytes are the CRC and are never pushed.
- CHECK (1 cycle):
  - Data with fewer than 2 bytes -> ERROR(LEN).
  - CRC16 over payload+CRC fails with CHECK_CRC=1 -> ERROR(CRC). CRC16: poly 16'h8005, init 16'hFFFF, LSB-first, register bit15 = x^15, residue 16'h800D.
  - Token with addr_check_en and addr ≠ dev_addr -> ERROR(ADDR).
  - Otherwise: rx_data_ready = 1 for 1 cycle. A token also latches rx_token_addr and rx_token_endp. Then -> EOP_LOW.
- ERROR: on entry, flush = 1 for 1 cycle, rx_error = 1, rx_error_code latched.
  - rx_error and rx_error_code stay until the next SYNC->PID transition or rst.
  - Stay in ERROR until eop, then -> EOP_LOW. Entry already in progress with eop high goes straight to EOP_LOW.
- EOP_LOW: wait for eop = 0, then -> IDLE.
- Simultaneous byte_received and eop: the byte is processed first, then eop is evaluated against the updated byte count in the same cycle.
- Error codes: NONE=0, SYNC=1, PID=2, CRC=3, LEN=4, OVF=5, ADDR=6, EOP_EARLY=7. The first error in a packet wins.

Decomposition:
- Package usb_rx_pkg:
  - pid_t enum: OUT 0001, IN 1001, SETUP 1101, DATA0 0011, DATA1 1011, ACK 0010, NAK 1010, STALL 1110.
  - rx_err_t enum.
  - rx_state_t.
  - Constants: SYNC_BYTE, CRC5_POLY, CRC5_RESIDUE, CRC16_POLY, CRC16_RESIDUE.
  - crc5_16b function.
- Sub-module usb_crc16_byte: combinational next-CRC16 from {crc_in, byte}. The controller registers its output per received byte.

Test Plan:
- Sync 8'h80, PID 8'hE1, 2 token bytes with model CRC5 for addr 7'h15 endp 4'hE, eop, dev_addr=7'h15, addr_check_en=1 -> rx_data_ready pulse, rx_packet=4'b0001, rx_token_addr=7'h15, rx_token_endp=4'hE, rx_error=0.
- Same token with dev_addr=7'h16 -> rx_error=1, rx_error_code=6, 1 flush pulse, no rx_data_ready.
- DATA0 (8'hC3), payload 00 01 02 03 plus model CRC16, eop -> flush at PID; 4 store pulses with data 00,01,02,03 in order; rx_byte_count=4; rx_data_ready pulse.
- Same packet with one payload bit flipped -> rx_error_code=3 with CHECK_CRC=1; no error with CHECK_CRC=0.
- PID byte 8'hE2 (bad complement) -> rx_error_code=2. The following good ACK packet (8'hD2) clears rx_error and sets rx_packet=4'b0010.
- MAX_DATA=8, 10 payload bytes plus CRC -> 8 pushes then ERROR(OVF=5). Separately, buffer_occupancy=64 at the first push -> OVF with no push. Separately, rst mid-payload -> all outputs 0 next cycle, no flush.
